// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: default widths,
// FSM state encodings and requester identifiers.
package regbank_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;

    // Access sequencer states: wait for a request, drive the bank, report back.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Identifies which requester owns (or last owned) the register bank.
    typedef enum logic {
        GRANT_SPI  = 1'b0,
        GRANT_HOST = 1'b1
    } grant_e;

endpackage

// File: rtl/regbank_arbiter_if.sv
// Bundle of the two requester ports and the register-bank port.
// The arbiter uses the slave view; requesters and the bank use the master view.
interface regbank_arbiter_if #(
    parameter int DATA_W = regbank_arbiter_pkg::DATA_W_DEF,
    parameter int ADDR_W = regbank_arbiter_pkg::ADDR_W_DEF
) ();

    logic              spi_req;
    logic              spi_we;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic              spi_gnt;
    logic              spi_rvalid;
    logic [DATA_W-1:0] spi_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              rb_wr;
    logic [ADDR_W-1:0] rb_address;
    logic [DATA_W-1:0] rb_data_out;
    logic [DATA_W-1:0] rb_data_in;

    modport slave (
        input  spi_req, spi_we, spi_addr, spi_wdata,
        output spi_gnt, spi_rvalid, spi_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output rb_wr, rb_address, rb_data_out,
        input  rb_data_in
    );

    modport master (
        output spi_req, spi_we, spi_addr, spi_wdata,
        input  spi_gnt, spi_rvalid, spi_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  rb_wr, rb_address, rb_data_out,
        output rb_data_in
    );

endinterface

// File: rtl/regbank_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_arb2
    import regbank_arbiter_pkg::*;
(
    input  logic [1:0] req_i,        // [0] = SPI, [1] = host
    input  grant_e     last_grant_i,
    output logic       valid_o,
    output grant_e     winner_o
);

    // Pick the winner from the request pair and the previous owner.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no latch is inferred.
        valid_o  = |req_i;
        winner_o = GRANT_SPI;
        if (req_i == 2'b11) begin
            winner_o = (last_grant_i == GRANT_SPI) ? GRANT_HOST : GRANT_SPI;
        end else if (req_i[1]) begin
            winner_o = GRANT_HOST;
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates SPI and local-host accesses onto a single register bank.
// Each access takes one ACCESS cycle (bank driven, gnt pulsed) followed by
// one RESP cycle (rvalid pulsed, next request may be accepted).
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic               clk,
    input logic               rst,
    regbank_arbiter_if.slave  bus
);

    state_e            state_q;
    grant_e            last_grant_q;
    grant_e            cur_q;
    logic              spi_gnt_q;
    logic              host_gnt_q;
    logic              spi_rvalid_q;
    logic              host_rvalid_q;
    logic [DATA_W-1:0] spi_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              rb_wr_q;
    logic [ADDR_W-1:0] rb_address_q;
    logic [DATA_W-1:0] rb_data_out_q;

    logic              arb_valid;
    grant_e            arb_winner;
    logic              win_we_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [DATA_W-1:0] win_wdata_d;

    rr_arb2 u_rr_arb2 (
        .req_i        ({bus.host_req, bus.spi_req}),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .winner_o     (arb_winner)
    );

    // Select the winning requester's command fields for latching.
    always_comb begin
        win_we_d    = bus.spi_we;
        win_addr_d  = bus.spi_addr;
        win_wdata_d = bus.spi_wdata;
        if (arb_winner == GRANT_HOST) begin
            win_we_d    = bus.host_we;
            win_addr_d  = bus.host_addr;
            win_wdata_d = bus.host_wdata;
        end
    end

    // Access sequencer with registered handshake and bank outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GRANT_HOST;
            cur_q         <= GRANT_SPI;
            spi_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            spi_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            spi_rdata_q   <= '0;
            host_rdata_q  <= '0;
            rb_wr_q       <= 1'b0;
            rb_address_q  <= '0;
            rb_data_out_q <= '0;
        end else begin
            // NOTE: non-blocking assignments; pulses default low and are raised below.
            spi_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            spi_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            rb_wr_q       <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (arb_valid) begin
                        state_q       <= ST_ACCESS;
                        cur_q         <= arb_winner;
                        last_grant_q  <= arb_winner;
                        rb_wr_q       <= win_we_d;
                        rb_address_q  <= win_addr_d;
                        rb_data_out_q <= win_wdata_d;
                        if (arb_winner == GRANT_SPI) begin
                            spi_gnt_q <= 1'b1;
                        end else begin
                            host_gnt_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // rb_wr_q still holds the latched write flag during ACCESS.
                    state_q <= ST_RESP;
                    if (cur_q == GRANT_SPI) begin
                        spi_rvalid_q <= 1'b1;
                        spi_rdata_q  <= rb_wr_q ? '0 : bus.rb_data_in;
                    end else begin
                        host_rvalid_q <= 1'b1;
                        host_rdata_q  <= rb_wr_q ? '0 : bus.rb_data_in;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.spi_gnt     = spi_gnt_q;
    assign bus.spi_rvalid  = spi_rvalid_q;
    assign bus.spi_rdata   = spi_rdata_q;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.rb_wr       = rb_wr_q;
    assign bus.rb_address  = rb_address_q;
    assign bus.rb_data_out = rb_data_out_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_regbank_arbiter;

    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regbank_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regbank_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register bank: combinational read, write on rising edge.
    logic [DW-1:0] bank [0:(1<<AW)-1] = '{default: '0};
    assign bus.rb_data_in = bank[bus.rb_address];
    always @(posedge clk) if (bus.rb_wr) bank[bus.rb_address] <= bus.rb_data_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: an access is accepted at any edge that does not end a
    // grant cycle; the edge ending a grant cycle returns the response.
    bit            m_spi_gnt, m_host_gnt, m_spi_rv, m_host_rv, m_wr;
    logic [DW-1:0] m_spi_rdata, m_host_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    int            m_last;   // 0 = SPI, 1 = host
    int            m_cur;
    logic [DW-1:0] m_mem [0:(1<<AW)-1] = '{default: '0};

    typedef struct {
        bit            host;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs [10];

    int ng, last_c, left_s, left_h, prev_g, grants;
    bit pend_s, pend_h;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_spi_gnt = 0; m_host_gnt = 0; m_spi_rv = 0; m_host_rv = 0; m_wr = 0;
        m_spi_rdata = '0; m_host_rdata = '0; m_wdata = '0; m_addr = '0;
        m_last = 1; m_cur = 0;
    endtask

    task automatic model_edge();
        int w;
        m_spi_rv  = 0;
        m_host_rv = 0;
        if (m_spi_gnt || m_host_gnt) begin
            if (m_cur == 0) begin
                m_spi_rv = 1;
                m_spi_rdata = m_wr ? '0 : m_mem[m_addr];
            end else begin
                m_host_rv = 1;
                m_host_rdata = m_wr ? '0 : m_mem[m_addr];
            end
            if (m_wr) m_mem[m_addr] = m_wdata;
            m_spi_gnt = 0; m_host_gnt = 0; m_wr = 0;
        end else begin
            w = -1;
            if (bus.spi_req && bus.host_req) w = (m_last == 0) ? 1 : 0;
            else if (bus.spi_req)            w = 0;
            else if (bus.host_req)           w = 1;
            if (w == 0) begin
                m_spi_gnt = 1; m_wr = bus.spi_we; m_addr = bus.spi_addr; m_wdata = bus.spi_wdata;
            end else if (w == 1) begin
                m_host_gnt = 1; m_wr = bus.host_we; m_addr = bus.host_addr; m_wdata = bus.host_wdata;
            end
            if (w >= 0) begin
                m_cur = w;
                m_last = w;
            end
        end
    endtask

    task automatic compare_all();
        check("spi_gnt",     64'(bus.spi_gnt),     64'(m_spi_gnt));
        check("host_gnt",    64'(bus.host_gnt),    64'(m_host_gnt));
        check("spi_rvalid",  64'(bus.spi_rvalid),  64'(m_spi_rv));
        check("host_rvalid", 64'(bus.host_rvalid), 64'(m_host_rv));
        check("spi_rdata",   64'(bus.spi_rdata),   64'(m_spi_rdata));
        check("host_rdata",  64'(bus.host_rdata),  64'(m_host_rdata));
        check("rb_wr",       64'(bus.rb_wr),       64'(m_wr));
        check("rb_address",  64'(bus.rb_address),  64'(m_addr));
        check("rb_data_out", 64'(bus.rb_data_out), 64'(m_wdata));
        check("one_gnt",     64'(bus.spi_gnt & bus.host_gnt), 64'(1'b0));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_req(input bit host, input bit req, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!host) begin
            bus.spi_req = req; bus.spi_we = we; bus.spi_addr = a; bus.spi_wdata = d;
        end else begin
            bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Protocol-abiding random requester: drop after grant, optionally raise or withdraw.
    task automatic drive_port(input bit host, input int raise_pct, input int withdraw_pct);
        bit g, r;
        g = host ? m_host_gnt : m_spi_gnt;
        r = host ? bus.host_req : bus.spi_req;
        if (g) begin
            if (host) bus.host_req = 0; else bus.spi_req = 0;
        end else if (!r) begin
            if (int'($urandom_range(99)) < raise_pct)
                set_req(host, 1, 1'($urandom_range(1)), AW'($urandom_range((1<<AW)-1)), DW'($urandom()));
        end else if (int'($urandom_range(99)) < withdraw_pct) begin
            if (host) bus.host_req = 0; else bus.spi_req = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 6'h3F, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 6'h3F, 32'h0,        32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 6'h00, 32'h0,        32'h0};
        vecs[5] = '{1'b1, 1'b1, 6'h00, 32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 6'h00, 32'h0,        32'hA5A5A5A5};
        vecs[7] = '{1'b0, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
        vecs[8] = '{1'b0, 1'b1, 6'h05, 32'h0BADF00D, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 6'h05, 32'h0,        32'h0BADF00D};

        // Reset state.
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        model_reset();
        #12;
        compare_all();
        check("rst_rb_wr",      64'(bus.rb_wr),      64'(0));
        check("rst_rb_address", 64'(bus.rb_address), 64'(0));
        check("rst_spi_rdata",  64'(bus.spi_rdata),  64'(0));
        rst = 1'b1;

        // Single-requester vector table.
        for (int i = 0; i < 10; i++) begin
            set_req(vecs[i].host, 1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            tick();
            check("vec_gnt",     64'(vecs[i].host ? bus.host_gnt : bus.spi_gnt), 64'(1));
            check("vec_gnt_oth", 64'(vecs[i].host ? bus.spi_gnt : bus.host_gnt), 64'(0));
            check("vec_rb_wr",   64'(bus.rb_wr),      64'(vecs[i].we));
            check("vec_rb_addr", 64'(bus.rb_address), 64'(vecs[i].addr));
            set_req(vecs[i].host, 0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            tick();
            check("vec_rvalid",  64'(vecs[i].host ? bus.host_rvalid : bus.spi_rvalid), 64'(1));
            check("vec_rdata",   64'(vecs[i].host ? bus.host_rdata : bus.spi_rdata), 64'(vecs[i].exp_rdata));
            check("vec_rb_wr_resp", 64'(bus.rb_wr), 64'(0));
            tick();
        end

        // Simultaneous requests after reset: SPI first, then strict alternation.
        do_reset();
        ng = 0; last_c = 0; left_s = 4; left_h = 4;
        set_req(0, 1, 1, 6'h11, 32'h1000_0000);
        set_req(1, 1, 0, 6'h11, 32'h0);
        for (int cyc = 1; cyc <= 40 && ng < 8; cyc++) begin
            tick();
            if (bus.spi_gnt || bus.host_gnt) begin
                check("tie_order", 64'(bus.host_gnt), 64'(ng % 2));
                if (ng > 0) check("tie_spacing", 64'(cyc - last_c), 64'(2));
                last_c = cyc;
                ng++;
            end
            if (m_spi_gnt) begin
                bus.spi_req = 0; left_s--;
            end else if (!bus.spi_req && left_s > 0) begin
                set_req(0, 1, 1, 6'h11, DW'(32'h1000_0000 + cyc));
            end
            if (m_host_gnt) begin
                bus.host_req = 0; left_h--;
            end else if (!bus.host_req && left_h > 0) begin
                set_req(1, 1, 0, 6'h11, '0);
            end
        end
        check("tie_grants", 64'(ng), 64'(8));
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        tick();
        tick();

        // Host request raised only during SPI's ACCESS cycle is ignored.
        set_req(0, 1, 0, 6'h05, '0);
        tick();
        check("wd_spi_gnt", 64'(bus.spi_gnt), 64'(1));
        bus.spi_req  = 0;
        bus.host_req = 1;
        tick();
        check("wd_spi_rvalid", 64'(bus.spi_rvalid), 64'(1));
        bus.host_req = 0;
        tick();
        check("wd_host_gnt", 64'(bus.host_gnt), 64'(0));
        tick();
        check("wd_host_gnt2",    64'(bus.host_gnt),    64'(0));
        check("wd_host_rvalid2", 64'(bus.host_rvalid), 64'(0));

        // Reset in the middle of a write ACCESS.
        set_req(0, 1, 1, 6'h0A, 32'h55AA1234);
        tick();
        check("rstmid_rb_wr_before", 64'(bus.rb_wr), 64'(1));
        #3;
        rst = 1'b0;
        #1;
        check("rstmid_rb_wr_async", 64'(bus.rb_wr),   64'(0));
        check("rstmid_gnt_async",   64'(bus.spi_gnt), 64'(0));
        set_req(0, 0, 0, '0, '0);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        check("rstmid_no_rvalid", 64'(bus.spi_rvalid), 64'(0));
        tick();
        set_req(0, 1, 0, 6'h0A, '0);
        set_req(1, 1, 0, 6'h0A, '0);
        tick();
        check("rstmid_tie_spi",  64'(bus.spi_gnt),  64'(1));
        check("rstmid_tie_host", 64'(bus.host_gnt), 64'(0));
        bus.spi_req = 0;
        tick();
        tick();
        check("rstmid_host_next", 64'(bus.host_gnt), 64'(1));
        bus.host_req = 0;
        tick();
        check("rstmid_host_rdata", 64'(bus.host_rdata), 64'(0));
        tick();

        // Continuous two-requester stress.
        prev_g = -1; grants = 0; pend_s = 0; pend_h = 0;
        for (int c = 0; c < 1000; c++) begin
            drive_port(0, 100, 0);
            drive_port(1, 100, 0);
            tick();
            if (pend_s) check("stress_spi_rvalid", 64'(bus.spi_rvalid), 64'(1));
            if (pend_h) check("stress_host_rvalid", 64'(bus.host_rvalid), 64'(1));
            pend_s = bus.spi_gnt;
            pend_h = bus.host_gnt;
            if (bus.spi_gnt || bus.host_gnt) begin
                if (prev_g >= 0) check("stress_alternate", 64'(bus.host_gnt), 64'(prev_g == 0));
                prev_g = bus.host_gnt ? 1 : 0;
                grants++;
            end
        end
        check("stress_grants", 64'(grants), 64'(500));
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        tick();
        tick();

        // Sparse random traffic with occasional withdrawals.
        for (int c = 0; c < 1500; c++) begin
            drive_port(0, 30, 5);
            drive_port(1, 30, 5);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 6, register address width.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port: spi_req  input  1  SPI-side access request, held with we/addr/wdata stable until spi_gnt.
REQ-006 Port: spi_we  input  1  SPI request is a write (1) or read (0).
REQ-007 Port: spi_addr  input  ADDR_W  SPI request address.
REQ-008 Port: spi_wdata  input  DATA_W  SPI write data.
REQ-009 Port: spi_gnt  output  1  one-cycle pulse: SPI request is being executed.
REQ-010 Port: spi_rvalid  output  1  one-cycle pulse: SPI access complete, spi_rdata valid.
REQ-011 Port: spi_rdata  output  DATA_W  SPI read data.
REQ-012 Port: host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata  same directions/widths/meaning as SPI ports, for the local host requester.
REQ-013 Port: rb_wr  output  1  register bank write strobe.
REQ-014 Port: rb_address  output  ADDR_W  register bank address.
REQ-015 Port: rb_data_out  output  DATA_W  write data to register bank.
REQ-016 Port: rb_data_in  input  DATA_W  register bank read data, combinational function of rb_address.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-018 IDLE: if any req high, latch winner's we/addr/wdata, go ACCESS; else stay IDLE.
REQ-019 ACCESS (1 cycle): rb_address=latched addr, rb_data_out=latched wdata, rb_wr=latched we, winner's gnt=1; at cycle end capture rb_data_in; go RESP.
REQ-020 RESP (1 cycle): winner's rvalid=1, winner's rdata=captured value for reads, 0 for writes; loser's rdata holds prior value; arbitrate as in IDLE and go ACCESS if any req high, else IDLE.
REQ-021 Latency: req high in IDLE at cycle 0 -> gnt cycle 1 -> rvalid cycle 2; back-to-back throughput one access per 2 cycles.
REQ-022 Arbitration: single requester wins; both requesting -> the one not granted last wins (round-robin); last_grant updated only on entry to ACCESS.
REQ-023 Requester shall drop req in the cycle after its gnt; req still high when sampled in RESP is a new access.
REQ-024 Req withdrawn before being sampled is ignored, no gnt/rvalid issued.
REQ-025 Outside ACCESS: rb_wr=0, rb_address and rb_data_out hold last values; gnt never high for both ports.

Reset
REQ-026 rst low asynchronously forces state IDLE, last_grant=HOST (SPI wins first tie), all gnt/rvalid/rb_wr=0, rdata/rb_address/rb_data_out=0.
REQ-027 Reset during ACCESS or RESP aborts the access: rb_wr drops immediately, no rvalid issued after release.
REQ-028 First arbitration occurs on the first rising clk edge with rst high.

Structure
REQ-029 DATA_W/ADDR_W defaults come from the shared spi defines file; FSM state encodings belong there as constants.
REQ-030 One sub-module rr_arb2: 2-input round-robin picker (req[1:0], last_grant -> winner), combinational.

Verification
REQ-031 SPI write alone: spi_req, we=1, addr=0x05, wdata=0xDEADBEEF in IDLE -> cycle1 rb_wr=1, rb_address=0x05, spi_gnt=1; cycle2 spi_rvalid=1, spi_rdata=0.
REQ-032 Host read after REQ-031: host_req, we=0, addr=0x05 -> host_gnt cycle1, host_rvalid cycle2 with host_rdata=0xDEADBEEF, rb_wr stays 0.
REQ-033 Simultaneous reqs after reset -> SPI granted first, host granted in the ACCESS following SPI's RESP (gnt 2 cycles apart), then alternation over 4 repeated accesses each.
REQ-034 Req withdrawn: host_req high one cycle while FSM in ACCESS for SPI, low before RESP -> no host_gnt, FSM to IDLE.
REQ-035 Reset mid-ACCESS of a write to 0x0A -> rb_wr low asynchronously, no rvalid after release, state IDLE, next tie goes to SPI.
REQ-036 Continuous both-req stress 1000 cycles -> never both gnt, grants alternate, each gnt followed by exactly one rvalid next cycle.
